// File: rtl/mult_hilo_ctrl_if.sv
// Signal bundle between the execute stage, the HI/LO front end and the
// 16x16 sequential multiplier (St/Idle/Done/Produto handshake).
interface mult_hilo_ctrl_if;
  logic        Op_valid;
  logic        Op_signed;
  logic [31:0] Op_a;
  logic [31:0] Op_b;
  logic        Mthi;
  logic        Mtlo;
  logic [31:0] Wr_data;
  logic        Rd_sel;
  logic        Rd_en;
  logic [31:0] Rd_data;
  logic        Stall;
  logic        Err;
  logic        Mul_St;
  logic [15:0] Mul_Multiplicador;
  logic [15:0] Mul_Multiplicando;
  logic        Mul_Idle;
  logic        Mul_Done;
  logic [31:0] Mul_Produto;

  modport slave (
    input  Op_valid, Op_signed, Op_a, Op_b, Mthi, Mtlo, Wr_data, Rd_sel, Rd_en,
    input  Mul_Idle, Mul_Done, Mul_Produto,
    output Rd_data, Stall, Err, Mul_St, Mul_Multiplicador, Mul_Multiplicando
  );

  modport master (
    output Op_valid, Op_signed, Op_a, Op_b, Mthi, Mtlo, Wr_data, Rd_sel, Rd_en,
    output Mul_Idle, Mul_Done, Mul_Produto,
    input  Rd_data, Stall, Err, Mul_St, Mul_Multiplicador, Mul_Multiplicando
  );
endinterface

// File: rtl/mult_hilo_ctrl.sv
// HI/LO front end: turns MULT/MULTU into magnitude launches on the sequential
// multiplier, sign-corrects the product into HI/LO and serves MFHI/MFLO/MTHI/MTLO.
//
// state  | meaning
// IDLE   | accept multiply, MTHI/MTLO writes; no stall
// LAUNCH | Mul_St high until the multiplier leaves idle
// RUN    | waiting for Mul_Done, product captured on Done
// WB     | sign-corrected product written to HI/LO
module mult_hilo_ctrl #(
  parameter int MAX_WAIT = 64,
  parameter int CW       = 7
) (
  input logic             Clk,
  input logic             Rst_n,
  mult_hilo_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_WB     = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          neg_q, neg_d;
  logic          sgn_q, sgn_d;
  logic [15:0]   mag_a_q, mag_a_d;
  logic [15:0]   mag_b_q, mag_b_d;
  logic          st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   prod_q, prod_d;
  logic          err_q, err_d;

  logic          wait_expired;
  logic [31:0]   prod_fix;
  logic          any_req;
  logic          unused_op_hi;

  // 0x8000 negates to itself, which reads correctly as unsigned 32768.
  function automatic logic [15:0] magnitude(input logic [15:0] v, input logic is_signed);
    return (is_signed && v[15]) ? (~v + 16'd1) : v;
  endfunction

  assign wait_expired = (cnt_q == CW'(MAX_WAIT - 1));
  assign prod_fix     = neg_q ? (32'd0 - prod_q) : prod_q;
  assign any_req      = bus.Op_valid | bus.Rd_en | bus.Mthi | bus.Mtlo;
  assign unused_op_hi = ^{bus.Op_a[31:16], bus.Op_b[31:16]};

  always_comb begin
    state_d = state_q;
    neg_d   = neg_q;
    sgn_d   = sgn_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    st_d    = st_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    prod_d  = prod_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.Mthi) hi_d = bus.Wr_data;
        if (bus.Mtlo) lo_d = bus.Wr_data;
        if (bus.Op_valid) begin
          neg_d   = bus.Op_signed & (bus.Op_a[15] ^ bus.Op_b[15]);
          sgn_d   = bus.Op_signed;
          mag_a_d = magnitude(bus.Op_a[15:0], bus.Op_signed);
          mag_b_d = magnitude(bus.Op_b[15:0], bus.Op_signed);
          st_d    = 1'b1;
          cnt_d   = '0;
          state_d = S_LAUNCH;
        end
      end

      S_LAUNCH: begin
        if (!bus.Mul_Idle) begin
          st_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end else if (wait_expired) begin
          st_d    = 1'b0;
          cnt_d   = cnt_q + CW'(1);
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end

      S_RUN: begin
        if (bus.Mul_Done) begin
          prod_d  = bus.Mul_Produto;
          state_d = S_WB;
        end else if (wait_expired) begin
          cnt_d   = cnt_q + CW'(1);
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end

      S_WB: begin
        lo_d    = prod_fix;
        hi_d    = sgn_q ? {32{prod_fix[31]}} : 32'd0;
        state_d = S_IDLE;
      end

      default: begin
        st_d    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      neg_q   <= 1'b0;
      sgn_q   <= 1'b0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      st_q    <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      prod_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      neg_q   <= neg_d;
      sgn_q   <= sgn_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      prod_q  <= prod_d;
      err_q   <= err_d;
    end
  end

  // Reads see the registered value, so a same-cycle MTHI/MTLO returns old data.
  assign bus.Rd_data           = bus.Rd_sel ? hi_q : lo_q;
  assign bus.Stall             = (state_q != S_IDLE) & any_req;
  assign bus.Err               = err_q;
  assign bus.Mul_St            = st_q;
  assign bus.Mul_Multiplicador = mag_a_q;
  assign bus.Mul_Multiplicando = mag_b_q;

endmodule

// File: doc/mult_hilo_ctrl.md
Name: mult_hilo_ctrl

Overview:
Pipeline-side front end for the 16x16 sequential multiplier (St/Idle/Done/Produto interface). Accepts MULT/MULTU requests from the execute stage, converts signed operands to magnitudes, and launches the multiplier. On Done it applies sign correction and writes the architectural HI/LO pair. It also serves MFHI/MFLO/MTHI/MTLO and raises a stall while a multiply is outstanding.

Parameters:
MAX_WAIT, 64, cycles allowed in any multiplier-wait state before timeout abort
CW, 7, width of the wait counter (must hold MAX_WAIT)

Ports:
Clk  in  1  system clock, rising edge
Rst_n  in  1  asynchronous active-low reset
Op_valid  in  1  multiply request from execute stage
Op_signed  in  1  1=MULT (signed), 0=MULTU
Op_a  in  32  operand A; only bits [15:0] used
Op_b  in  32  operand B; only bits [15:0] used
Mthi  in  1  write Wr_data to HI
Mtlo  in  1  write Wr_data to LO
Wr_data  in  32  data for MTHI/MTLO
Rd_sel  in  1  0=LO, 1=HI
Rd_en  in  1  MFHI/MFLO request
Rd_data  out  32  selected HI/LO value (combinational)
Stall  out  1  hold execute stage
Err  out  1  sticky timeout flag
Mul_St  out  1  start to multiplier
Mul_Multiplicador  out  16  operand magnitude A
Mul_Multiplicando  out  16  operand magnitude B
Mul_Idle  in  1  multiplier idle
Mul_Done  in  1  multiplier result valid (pulse)
Mul_Produto  in  32  unsigned product

Behaviour:
- Clock Clk; reset Rst_n asynchronous, active-low. Reset clears state to IDLE, and clears HI, LO, Err, Mul_St, Mul_Multiplicador, Mul_Multiplicando and the wait counter to 0. Stall=0 in reset.
- States: IDLE, LAUNCH, RUN, WB.
- IDLE: on Op_valid, register neg = Op_signed & (a[15]^b[15]). Register magnitudes: for signed ops, a negative operand becomes its two's-complement negation (0x8000 -> 0x8000, unsigned 32768); unsigned ops pass through. Go to LAUNCH. Accept cycle: Stall=0.
- LAUNCH: Mul_St=1 (registered). Hold until Mul_Idle=0, then drop Mul_St and go to RUN.
- RUN: Mul_St=0; wait for Mul_Done=1, then go to WB.
- WB: one cycle. P = neg ? -Mul_Produto : Mul_Produto. LO<=P; HI <= Op_signed ? {32{P[31]}} : 0. Return to IDLE. The Mul_Produto capture is taken on the Mul_Done cycle.
- Operand outputs stay stable from LAUNCH through WB.
- Timeout: counter resets on entry to LAUNCH and to RUN. Counter reaching MAX_WAIT -> Err<=1, HI/LO unchanged, go to IDLE. Err clears only on reset.
- Stall=1 in LAUNCH, RUN and WB whenever Op_valid, Rd_en, Mthi or Mtlo is asserted. Those requests are ignored until IDLE.
- In IDLE, Mthi/Mtlo write on the clock edge. Mthi+Mtlo together write both.
- Op_valid with Mthi/Mtlo in the same IDLE cycle: both are honoured. The later WB overwrites HI/LO.
- Rd_data = Rd_sel ? HI : LO, combinational. A read in the same cycle as a Mt* write returns the old value.
- Reset mid-operation returns to IDLE immediately and Mul_St drops. A multiplier Done arriving afterwards is ignored in IDLE.
- Zero result with neg=1 yields 0 (negation of 0).
- Latency: accept-to-HI/LO-valid = 1 + (cycles until Idle drops) + multiplier run + 1.

Test Plan:
- Unsigned 2001*4001 (0x07D1, 0x0FA1) -> LO=0x007A2971, HI=0; Stall asserted on a concurrent Rd_en until WB completes.
- Signed 0xFFFE*0x0003 (-2*3) -> magnitudes 2 and 3 on the multiplier port, LO=0xFFFFFFFA, HI=0xFFFFFFFF.
- Signed 0x8000*0x8000 -> magnitudes 0x8000/0x8000, LO=0x40000000, HI=0. Signed 0x8000*0x0001 -> LO=0xFFFF8000, HI=0xFFFFFFFF.
- Unsigned 0xFFFF*0xFFFF -> LO=0xFFFE0001, HI=0. Signed 0x0000*0xFFFB -> LO=0, HI=0.
- Mul_Idle stuck high after launch -> Err=1 after 64 cycles, HI/LO keep prior MTHI/MTLO values (0x12345678/0x9ABCDEF0), state IDLE, Stall=0.
- Rst_n pulsed low during RUN -> HI=LO=0, Mul_St=0, Stall=0. A later stray Mul_Done leaves HI/LO=0. A following MTLO 0x55 then MFLO returns 0x55.
